// File: rtl/pulp_cg_pkg.sv
// Shared types and default sizing for the automatic clock-gate controller.
// Every channel FSM and the top-level debug port use cg_state_e.
package pulp_cg_pkg;

   localparam int unsigned CG_N_CH_DEF        = 4;
   localparam int unsigned CG_CNT_W_DEF       = 8;
   localparam int unsigned CG_WAKE_CYCLES_DEF = 2;

   typedef enum logic [1:0] {
      CG_ON    = 2'd0,
      CG_COUNT = 2'd1,
      CG_GATED = 2'd2,
      CG_WAKE  = 2'd3
   } cg_state_e;

   // The gating cell is enabled in every state except GATED.
   function automatic logic cg_state_enables(input cg_state_e s);
      return (s != CG_GATED);
   endfunction

endpackage

// File: rtl/pulp_cg_channel.sv
// One gating channel: idle counter, ON/COUNT/GATED/WAKE FSM, registered enable.
// The FSM state is exported on state_o for debug and checker binding.
module pulp_cg_channel
   import pulp_cg_pkg::*;
#(
   parameter int unsigned CNT_W       = CG_CNT_W_DEF,
   parameter int unsigned WAKE_CYCLES = CG_WAKE_CYCLES_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             test_en_i,
   input  logic             cfg_auto_i,
   input  logic [CNT_W-1:0] idle_thr_i,
   input  logic             busy_i,
   input  logic             wake_req_i,
   output logic             wake_ack_o,
   output logic             clk_en_o,
   output logic             gated_o,
   output cg_state_e        state_o
);

   cg_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             en_q;

   logic             idle;
   logic             thr_zero;
   logic             thr_one;
   logic [CNT_W:0]   cnt_inc;
   logic [CNT_W-1:0] cnt_sat;

   assign thr_zero = (idle_thr_i == '0);
   assign thr_one  = (idle_thr_i == CNT_W'(1));
   assign idle     = cfg_auto_i & ~busy_i & ~wake_req_i & ~thr_zero;

   // One bit wider so cnt+1 never wraps before being compared with the threshold.
   assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CG_ON: begin
            cnt_d = '0;
            if (idle) begin
               if (thr_one) begin
                  state_d = CG_GATED;
               end else begin
                  state_d = CG_COUNT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         CG_COUNT: begin
            if (!idle) begin
               state_d = CG_ON;
               cnt_d   = '0;
            end else if (cnt_inc >= {1'b0, idle_thr_i}) begin
               state_d = CG_GATED;
               cnt_d   = cnt_sat;
            end else begin
               cnt_d   = cnt_sat;
            end
         end
         CG_GATED: begin
            if (wake_req_i || !cfg_auto_i || thr_zero) begin
               state_d = CG_WAKE;
               cnt_d   = CNT_W'(WAKE_CYCLES);
            end
         end
         CG_WAKE: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = CG_ON;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = CG_ON;
            cnt_d   = '0;
         end
      endcase
      if (test_en_i) begin
         state_d = CG_ON;
         cnt_d   = '0;
      end
   end

   // Enable is registered from the next state so it changes on the same edge as the FSM.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= CG_ON;
         cnt_q   <= '0;
         en_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= cg_state_enables(state_d);
      end
   end

   // Handshake: wake_req_i is a level held by the requester until it sees
   // wake_ack_o high; ack is combinational (ON & req), so it rises in the first
   // ON cycle with the request present and falls as soon as the request drops.
   assign wake_ack_o = (state_q == CG_ON) & wake_req_i;
   assign clk_en_o   = en_q;
   assign gated_o    = (state_q == CG_GATED);
   assign state_o    = state_q;

endmodule

// File: rtl/pulp_clock_gate_ctrl.sv
// Multi-channel automatic clock-gate controller: N_CH independent channels plus
// a DFT override that forces every clock enable high.
module pulp_clock_gate_ctrl
   import pulp_cg_pkg::*;
#(
   parameter int unsigned N_CH        = CG_N_CH_DEF,
   parameter int unsigned CNT_W       = CG_CNT_W_DEF,
   parameter int unsigned WAKE_CYCLES = CG_WAKE_CYCLES_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  test_en_i,
   input  logic [N_CH-1:0]       cfg_auto_i,
   input  logic [CNT_W-1:0]      idle_thr_i,
   input  logic [N_CH-1:0]       busy_i,
   input  logic [N_CH-1:0]       wake_req_i,
   output logic [N_CH-1:0]       wake_ack_o,
   output logic [N_CH-1:0]       clk_en_o,
   output logic [N_CH-1:0]       gated_o,
   output cg_state_e [N_CH-1:0]  dbg_state_o
);

   logic [N_CH-1:0] ch_en;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      pulp_cg_channel #(
         .CNT_W       (CNT_W),
         .WAKE_CYCLES (WAKE_CYCLES)
      ) u_ch (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .test_en_i  (test_en_i),
         .cfg_auto_i (cfg_auto_i[c]),
         .idle_thr_i (idle_thr_i),
         .busy_i     (busy_i[c]),
         .wake_req_i (wake_req_i[c]),
         .wake_ack_o (wake_ack_o[c]),
         .clk_en_o   (ch_en[c]),
         .gated_o    (gated_o[c]),
         .state_o    (dbg_state_o[c])
      );
   end

   // Test mode must reach the gating cells without waiting for a clock edge.
   assign clk_en_o = ch_en | {N_CH{test_en_i}};

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Self-checking bench for pulp_clock_gate_ctrl: directed scenarios plus a
// randomized run compared against an idle-run / wake-countdown reference model.
module tb_pulp_clock_gate_ctrl;
   import pulp_cg_pkg::*;

   localparam int N_CH  = 4;
   localparam int CNT_W = 8;
   localparam int WAKE  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              test_en = 1'b0;
   logic [N_CH-1:0]   cfg_auto = '0;
   logic [CNT_W-1:0]  idle_thr = '0;
   logic [N_CH-1:0]   busy = '0;
   logic [N_CH-1:0]   wake_req = '0;
   logic [N_CH-1:0]   wake_ack;
   logic [N_CH-1:0]   clk_en;
   logic [N_CH-1:0]   gated;
   cg_state_e [N_CH-1:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: length of the current idle run, gated flag, wake countdown.
   bit        m_gated [N_CH];
   int        m_wake  [N_CH];
   int        m_run   [N_CH];
   logic [N_CH-1:0] exp_en, exp_gated, exp_ack;
   cg_state_e exp_state [N_CH];

   pulp_clock_gate_ctrl #(
      .N_CH        (N_CH),
      .CNT_W       (CNT_W),
      .WAKE_CYCLES (WAKE)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .test_en_i   (test_en),
      .cfg_auto_i  (cfg_auto),
      .idle_thr_i  (idle_thr),
      .busy_i      (busy),
      .wake_req_i  (wake_req),
      .wake_ack_o  (wake_ack),
      .clk_en_o    (clk_en),
      .gated_o     (gated),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout n_checks=%0d", n_checks);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_gated[c] = 1'b0;
         m_wake[c]  = 0;
         m_run[c]   = 0;
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < N_CH; c++) begin
         bit idle;
         idle = cfg_auto[c] && !busy[c] && !wake_req[c] && (idle_thr != 0);
         if (test_en) begin
            m_gated[c] = 1'b0;
            m_wake[c]  = 0;
            m_run[c]   = 0;
         end else if (m_wake[c] > 0) begin
            m_wake[c] = m_wake[c] - 1;
         end else if (m_gated[c]) begin
            if (wake_req[c] || !cfg_auto[c] || idle_thr == 0) begin
               m_gated[c] = 1'b0;
               m_wake[c]  = WAKE;
            end
         end else if (idle) begin
            m_run[c] = m_run[c] + 1;
            if (m_run[c] >= int'(idle_thr)) begin
               m_gated[c] = 1'b1;
               m_run[c]   = 0;
            end
         end else begin
            m_run[c] = 0;
         end
      end
   endtask

   task automatic model_outputs();
      for (int c = 0; c < N_CH; c++) begin
         exp_en[c]    = !m_gated[c] || test_en;
         exp_gated[c] = m_gated[c];
         exp_ack[c]   = !m_gated[c] && (m_wake[c] == 0) && wake_req[c];
         if (m_wake[c] > 0)     exp_state[c] = CG_WAKE;
         else if (m_gated[c])   exp_state[c] = CG_GATED;
         else if (m_run[c] > 0) exp_state[c] = CG_COUNT;
         else                   exp_state[c] = CG_ON;
      end
   endtask

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      #1;
      model_outputs();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (clk_en !== 4'hF) begin n_errors++; $display("FAIL reset_clk_en got=%b exp=%b", clk_en, 4'hF); end
      n_checks++;
      if (gated !== 4'h0) begin n_errors++; $display("FAIL reset_gated got=%b exp=%b", gated, 4'h0); end
      n_checks++;
      if (wake_ack !== 4'h0) begin n_errors++; $display("FAIL reset_ack got=%b exp=%b", wake_ack, 4'h0); end
      for (int c = 0; c < N_CH; c++) begin
         n_checks++;
         if (dbg_state[c] !== CG_ON) begin
            n_errors++; $display("FAIL reset_state ch=%0d got=%0d exp=%0d", c, dbg_state[c], CG_ON);
         end
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_gate();
      idle_thr = 8'd4;
      cfg_auto = 4'hF;
      busy     = 4'b1110;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (clk_en !== 4'hF) begin n_errors++; $display("FAIL gate_early edge=%0d got=%b exp=%b", i + 1, clk_en, 4'hF); end
      end
      tick();
      n_checks++;
      if (clk_en !== 4'b1110) begin n_errors++; $display("FAIL gate_en got=%b exp=%b", clk_en, 4'b1110); end
      n_checks++;
      if (gated !== 4'b0001) begin n_errors++; $display("FAIL gate_status got=%b exp=%b", gated, 4'b0001); end
      n_checks++;
      if (dbg_state[0] !== CG_GATED) begin n_errors++; $display("FAIL gate_state got=%0d exp=%0d", dbg_state[0], CG_GATED); end
   endtask

   task automatic wake_ch(input int c, input string tag);
      wake_req[c] = 1'b1;
      tick();
      n_checks++;
      if (clk_en[c] !== 1'b1 || wake_ack[c] !== 1'b0 || dbg_state[c] !== CG_WAKE) begin
         n_errors++; $display("FAIL %s_wake1 ch=%0d en=%b ack=%b st=%0d exp en=1 ack=0 st=%0d", tag, c, clk_en[c], wake_ack[c], dbg_state[c], CG_WAKE);
      end
      tick();
      n_checks++;
      if (wake_ack[c] !== 1'b0) begin n_errors++; $display("FAIL %s_ack_early ch=%0d got=%b exp=0", tag, c, wake_ack[c]); end
      tick();
      n_checks++;
      if (wake_ack[c] !== 1'b1 || dbg_state[c] !== CG_ON) begin
         n_errors++; $display("FAIL %s_ack ch=%0d ack=%b st=%0d exp ack=1 st=%0d", tag, c, wake_ack[c], dbg_state[c], CG_ON);
      end
      wake_req[c] = 1'b0;
      busy        = 4'hF;
      #1;
      n_checks++;
      if (wake_ack[c] !== 1'b0) begin n_errors++; $display("FAIL %s_ack_drop ch=%0d got=%b exp=0", tag, c, wake_ack[c]); end
      tick();
      n_checks++;
      if (dbg_state[c] !== CG_ON || clk_en[c] !== 1'b1) begin
         n_errors++; $display("FAIL %s_on ch=%0d st=%0d en=%b exp st=%0d en=1", tag, c, dbg_state[c], clk_en[c], CG_ON);
      end
   endtask

   task automatic test_wake();
      wake_ch(0, "wake");
   endtask

   task automatic test_busy_restart();
      busy = 4'b1110;
      repeat (3) tick();
      n_checks++;
      if (dbg_state[0] !== CG_COUNT) begin n_errors++; $display("FAIL restart_count got=%0d exp=%0d", dbg_state[0], CG_COUNT); end
      busy = 4'b1111;
      tick();
      n_checks++;
      if (dbg_state[0] !== CG_ON || clk_en[0] !== 1'b1) begin
         n_errors++; $display("FAIL restart_pulse st=%0d en=%b exp st=%0d en=1", dbg_state[0], clk_en[0], CG_ON);
      end
      busy = 4'b1110;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (clk_en[0] !== 1'b1) begin n_errors++; $display("FAIL restart_nogate edge=%0d got=%b exp=1", i + 1, clk_en[0]); end
      end
      tick();
      n_checks++;
      if (clk_en[0] !== 1'b0) begin n_errors++; $display("FAIL restart_gate got=%b exp=0", clk_en[0]); end
      wake_ch(0, "restart");
   endtask

   task automatic test_thr_lower();
      idle_thr = 8'd10;
      busy     = 4'b1110;
      repeat (5) tick();
      n_checks++;
      if (dbg_state[0] !== CG_COUNT || clk_en[0] !== 1'b1) begin
         n_errors++; $display("FAIL thr_count st=%0d en=%b exp st=%0d en=1", dbg_state[0], clk_en[0], CG_COUNT);
      end
      idle_thr = 8'd2;
      tick();
      n_checks++;
      if (gated[0] !== 1'b1 || clk_en[0] !== 1'b0) begin
         n_errors++; $display("FAIL thr_lower gated=%b en=%b exp gated=1 en=0", gated[0], clk_en[0]);
      end
      idle_thr = 8'd0;
      tick();
      n_checks++;
      if (dbg_state[0] !== CG_WAKE || clk_en[0] !== 1'b1) begin
         n_errors++; $display("FAIL thr_zero_wake st=%0d en=%b exp st=%0d en=1", dbg_state[0], clk_en[0], CG_WAKE);
      end
      repeat (2) tick();
      n_checks++;
      if (dbg_state[0] !== CG_ON || gated[0] !== 1'b0) begin
         n_errors++; $display("FAIL thr_zero_on st=%0d gated=%b exp st=%0d gated=0", dbg_state[0], gated[0], CG_ON);
      end
      busy = 4'hF;
      tick();
   endtask

   task automatic test_test_en();
      idle_thr = 8'd2;
      busy     = 4'b1101;
      repeat (2) tick();
      n_checks++;
      if (gated[1] !== 1'b1) begin n_errors++; $display("FAIL testen_pre_gated got=%b exp=1", gated[1]); end
      test_en = 1'b1;
      #1;
      n_checks++;
      if (clk_en !== 4'hF) begin n_errors++; $display("FAIL testen_force got=%b exp=%b", clk_en, 4'hF); end
      tick();
      n_checks++;
      if (dbg_state[1] !== CG_ON || gated[1] !== 1'b0) begin
         n_errors++; $display("FAIL testen_on st=%0d gated=%b exp st=%0d gated=0", dbg_state[1], gated[1], CG_ON);
      end
      test_en = 1'b0;
      tick();
      n_checks++;
      if (dbg_state[1] !== CG_COUNT || clk_en[1] !== 1'b1) begin
         n_errors++; $display("FAIL testen_recount st=%0d en=%b exp st=%0d en=1", dbg_state[1], clk_en[1], CG_COUNT);
      end
      tick();
      n_checks++;
      if (gated[1] !== 1'b1 || clk_en[1] !== 1'b0) begin
         n_errors++; $display("FAIL testen_regate gated=%b en=%b exp gated=1 en=0", gated[1], clk_en[1]);
      end
      wake_ch(1, "testen");
   endtask

   task automatic test_async_reset();
      idle_thr = 8'd1;
      busy     = 4'b1011;
      tick();
      n_checks++;
      if (gated[2] !== 1'b1) begin n_errors++; $display("FAIL arst_pre_gated got=%b exp=1", gated[2]); end
      busy     = 4'hF;
      wake_req = 4'b0100;
      tick();
      n_checks++;
      if (dbg_state[2] !== CG_WAKE) begin n_errors++; $display("FAIL arst_pre_wake got=%0d exp=%0d", dbg_state[2], CG_WAKE); end
      #2;
      rst      = 1'b1;
      wake_req = 4'h0;
      #1;
      n_checks++;
      if (clk_en !== 4'hF || gated !== 4'h0 || wake_ack !== 4'h0) begin
         n_errors++; $display("FAIL arst_outputs en=%b gated=%b ack=%b exp en=1111 gated=0000 ack=0000", clk_en, gated, wake_ack);
      end
      n_checks++;
      if (dbg_state[2] !== CG_ON) begin n_errors++; $display("FAIL arst_state got=%0d exp=%0d", dbg_state[2], CG_ON); end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_random();
      idle_thr = 8'd3;
      cfg_auto = 4'hF;
      busy     = 4'h0;
      wake_req = 4'h0;
      test_en  = 1'b0;
      model_outputs();
      for (int cyc = 0; cyc < 600; cyc++) begin
         if ($urandom_range(0, 15) == 0) idle_thr = CNT_W'($urandom_range(0, 5));
         for (int c = 0; c < N_CH; c++) begin
            if ($urandom_range(0, 31) == 0) cfg_auto[c] = ~cfg_auto[c];
            busy[c] = ($urandom_range(0, 3) == 0);
            if (wake_req[c]) begin
               if (exp_ack[c]) wake_req[c] = 1'b0;
            end else if ($urandom_range(0, 11) == 0) begin
               wake_req[c] = 1'b1;
            end
         end
         test_en = ($urandom_range(0, 39) == 0);
         tick();
         n_checks++;
         if (clk_en !== exp_en) begin n_errors++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", cyc, clk_en, exp_en); end
         n_checks++;
         if (gated !== exp_gated) begin n_errors++; $display("FAIL rnd_gated cyc=%0d got=%b exp=%b", cyc, gated, exp_gated); end
         n_checks++;
         if (wake_ack !== exp_ack) begin n_errors++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, wake_ack, exp_ack); end
         for (int c = 0; c < N_CH; c++) begin
            n_checks++;
            if (dbg_state[c] !== exp_state[c]) begin
               n_errors++; $display("FAIL rnd_state cyc=%0d ch=%0d got=%0d exp=%0d", cyc, c, dbg_state[c], exp_state[c]);
            end
         end
      end
      test_en = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      model_reset();
      test_reset();
      test_gate();
      test_wake();
      test_busy_restart();
      test_thr_lower();
      test_test_en();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
